axi_lite_sram: RTL and testbench
================================

# axi_lite_sram

AXI4-Lite slave memory that terminates the data-side port of the CPU's bus arbiter; it serves both instruction fetches and load/store traffic routed through that arbiter. Read and write channels run independent state machines, each with a programmable response latency. Out-of-range accesses return SLVERR. Its purpose is to exercise the IFU/WBU handshakes under realistic multi-cycle latency.

## Interface

Parameters:
- `BASE` — 32'h8000_0000 — byte address of word 0.
- `DEPTH_LOG2` — 12 — log2 of word count (default 4096 words = 16 KiB).
- `LAT` — 1 — fixed wait cycles between address/data acceptance and response (0..15).

Ports:
- `clk` in 1 — single clock; all logic is posedge.
- `rst` in 1 — synchronous, active-high reset.
- `arvalid` in 1, `araddr` in 32, `arready` out 1 — read address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out 32, `rresp` out 2 — read data channel.
- `awvalid` in 1, `awaddr` in 32, `awready` out 1 — write address channel.
- `wvalid` in 1, `wdata` in 32, `wstrb` in 8, `wready` out 1 — write data channel.
- `bvalid` out 1, `bready` in 1, `bresp` out 2 — write response channel.

## Operation

- Storage: `2**DEPTH_LOG2` × 32-bit array; contents are not reset.
- Word index is `(addr - BASE) >> 2`. `addr[1:0]` is ignored.
- An address is in range iff `BASE <= addr < BASE + 4*2**DEPTH_LOG2`.
- Read FSM states: R_IDLE → R_WAIT → R_RESP → R_IDLE.
  - `arready = (state == R_IDLE)`.
  - On `arvalid && arready`: latch the address and load a 4-bit counter with the latency.
  - R_WAIT: the counter decrements each cycle. At 0, the array word is registered into `rdata`, `rresp` is set, and the FSM enters R_RESP.
  - R_RESP: `rvalid = 1`. `rdata`/`rresp` are held stable until `rready`; on the handshake the FSM returns to R_IDLE.
- Write FSM states: W_IDLE → W_WAIT → W_RESP → W_IDLE.
  - In W_IDLE, `awready`/`wready` are each high until their own beat is captured. AW and W may arrive in either order or in the same cycle.
  - When both are captured, the counter loads and the FSM enters W_WAIT.
  - At counter 0, bytes are committed with `wstrb[3:0]` as byte enables; `wstrb[7:4]` is ignored. The FSM then enters W_RESP with `bvalid = 1`.
  - `bvalid` is held until `bready`; the FSM then returns to W_IDLE.
- Response codes: 2'b00 OKAY for in range. 2'b10 SLVERR for out of range, with `rdata = 0` and no array write.
- The read and write FSMs are fully independent and may be active at the same time.
- Same-word read/write ordering: a write commit and a read sample on the same edge return the OLD data. A commit on any earlier edge is visible to the read.

## Timing

- Reset values (registered outputs, first edge with `rst=1`):
  - `rvalid=0`, `bvalid=0`, `rdata=0`, `rresp=0`, `bresp=0`.
  - Both FSMs in IDLE, so `arready=awready=wready=1`.
- Read latency: AR handshake at edge T → `rvalid` high after edge T+L+1, where L is the latency (`LAT`, or the random value below).
- Write latency: the later of the AW/W handshakes at edge T → `bvalid` high after edge T+L+1.
- No back-to-back issue: `arready` returns one cycle after the R handshake, and `awready`/`wready` one cycle after the B handshake.
- Reset mid-transaction: all FSMs return to IDLE on that edge. A write still in W_WAIT is discarded (no commit), and pending responses are dropped.
- Valid/ready never depend combinationally on the same-channel valid/ready input.

## Configuration

- `AXI_SRAM_RANDOM_DELAY_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on `rst`) advances every cycle.
  - Each channel loads its counter with `lfsr[2:0]` (0..7) at its acceptance edge, so response latency is 1..8 cycles.
  - `LAT` is unused.
- Undefined: the counter loads `LAT`; no LFSR is instantiated.

## Test plan

- Reset then idle: `rst` high 2 cycles → `arready=awready=wready=1`, `rvalid=bvalid=0`, `rdata=0`.
- Full write then read (LAT=1):
  - AW+W same cycle, addr 8000_0010, data DEADBEEF, wstrb 0F → `bvalid` 2 cycles later, `bresp=00`.
  - Then AR 8000_0010 → `rvalid` 2 cycles after handshake, `rdata=DEADBEEF`, `rresp=00`.
- Byte strobe: over DEADBEEF write 0000_00AA with wstrb 01 → read returns DEADBEAA.
- W before AW: W at cycle 0, AW at cycle 3 → `wready` low cycles 1–3; `bvalid` at cycle 5; data committed.
- Out of range and backpressure:
  - AR 0000_0000 → `rresp=10`, `rdata=0`.
  - Hold `rready=0` 4 cycles → `rvalid`/`rdata` stable, `arready=0` throughout.
- Reset mid-write: `rst` asserted during W_WAIT → `bvalid` never asserts; a subsequent read returns the previous contents.

Source files
------------

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave SRAM with independent read/write FSMs and a programmable response latency.
// Define AXI_SRAM_RANDOM_DELAY_EN to draw each latency from an LFSR instead of LAT.
module axi_lite_sram #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LAT        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  output logic        arready,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  output logic        awready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);

  // Handshake rule on every channel: a beat transfers on a rising edge where valid && ready;
  // ready/valid outputs are decoded from registered state only, never from same-channel inputs.

  localparam int          WORDS  = 2 ** DEPTH_LOG2;
  localparam logic [32:0] SPAN   = 33'd4 << DEPTH_LOG2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [0:WORDS-1];

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [31:0] ar_addr;
  logic [3:0]  r_cnt;
  logic [31:0] aw_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        aw_got;
  logic        w_got;
  logic [3:0]  w_cnt;
  logic [3:0]  lat_load;

  logic        aw_fire;
  logic        w_fire;
  logic        r_done;
  logic        w_done;

  logic [32:0]           r_off;
  logic [32:0]           w_off;
  logic                  r_in_range;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DEPTH_LOG2-1:0] w_idx;

  logic unused_strb_hi;
  assign unused_strb_hi = &{1'b0, wstrb[7:4]};

`ifdef AXI_SRAM_RANDOM_DELAY_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  assign lat_load = {1'b0, lfsr[2:0]};
`else
  assign lat_load = 4'(LAT);
`endif

  // Offsets are 33 bits wide so an address below BASE shows up as a borrow rather than wrapping.
  assign r_off      = {1'b0, ar_addr} - {1'b0, BASE};
  assign w_off      = {1'b0, aw_addr} - {1'b0, BASE};
  assign r_in_range = !r_off[32] && (r_off < SPAN);
  assign w_in_range = !w_off[32] && (w_off < SPAN);
  assign r_idx      = r_off[DEPTH_LOG2+1:2];
  assign w_idx      = w_off[DEPTH_LOG2+1:2];

  // ---------------- read channel ----------------
  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);
  assign r_done  = (r_state == R_WAIT) && (r_cnt == 4'd0);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid) r_next = R_WAIT;
      R_WAIT:  if (r_cnt == 4'd0) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      ar_addr <= 32'd0;
      r_cnt   <= 4'd0;
      rdata   <= 32'd0;
      rresp   <= OKAY;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && arvalid) begin
        ar_addr <= araddr;
        r_cnt   <= lat_load;
      end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_done) begin
        if (r_in_range) begin
          rdata <= mem[r_idx];
          rresp <= OKAY;
        end else begin
          rdata <= 32'd0;
          rresp <= SLVERR;
        end
      end
    end
  end

  // ---------------- write channel ----------------
  assign awready = (w_state == W_IDLE) && !aw_got;
  assign wready  = (w_state == W_IDLE) && !w_got;
  assign bvalid  = (w_state == W_RESP);
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign w_done  = (w_state == W_WAIT) && (w_cnt == 4'd0);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if ((aw_got || aw_fire) && (w_got || w_fire)) w_next = W_WAIT;
      W_WAIT:  if (w_cnt == 4'd0) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_addr <= 32'd0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      w_cnt   <= 4'd0;
      bresp   <= OKAY;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        aw_addr <= awaddr;
        aw_got  <= 1'b1;
      end
      if (w_fire) begin
        w_data <= wdata;
        w_strb <= wstrb[3:0];
        w_got  <= 1'b1;
      end
      // Capture flags clear as the pair is consumed, so both readies reopen only after B.
      if (w_state == W_IDLE && w_next == W_WAIT) begin
        w_cnt  <= lat_load;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else if (w_state == W_WAIT && w_cnt != 4'd0) begin
        w_cnt <= w_cnt - 4'd1;
      end
      if (w_done) begin
        bresp <= w_in_range ? OKAY : SLVERR;
      end
    end
  end

  // Array has no reset; a reset landing on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && w_done && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: vector table through read/write tasks with a
// response scoreboard, plus hand-written sequences for ordering, backpressure and reset.
module tb_axi_lite_sram;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  axi_lite_sram #(.BASE(32'h8000_0000), .DEPTH_LOG2(12), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [1:0]  bexp_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [7:0] strb, input logic [1:0] eresp, input string name);
    int n;
    logic [1:0] e;
    bexp_q.push_back(eresp);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    if (!bvalid) begin
      timeout_fail({name, "_bvalid"});
    end else begin
      check({name, "_blat"}, 64'(n), 64'(LAT + 2));
      e = bexp_q.pop_front();
      check({name, "_bresp"}, 64'(bresp), 64'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] edata,
                         input logic [1:0] eresp, input int hold, input string name);
    int n;
    logic [33:0] e;
    exp_q.push_back({eresp, edata});
    araddr = addr;
    arvalid = 1'b1;
    rready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    if (!rvalid) begin
      timeout_fail({name, "_rvalid"});
    end else begin
      check({name, "_rlat"}, 64'(n), 64'(LAT + 2));
      e = exp_q.pop_front();
      check({name, "_rdata"}, 64'(rdata), 64'(e[31:0]));
      check({name, "_rresp"}, 64'(rresp), 64'(e[33:32]));
      // Backpressure: response must sit still and AR must stay closed.
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, "_hold"}, {31'd0, rvalid, arready, rresp, rdata},
                               {31'd0, 1'b1, 1'b0, e[33:32], e[31:0]});
      end
      if (hold != 0) begin
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, "_arready_back"}, {62'd0, arready, rvalid}, {62'd0, 1'b1, 1'b0});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    logic saw_b;

    vecs.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 8'h00, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0010, 32'h0000_00AA, 8'h01, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'hDEAD_BEAA, 8'h00, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0014, 32'hCAFE_F00D, 8'hFF, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0014, 32'hCAFE_F00D, 8'h00, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0014, 32'h1234_5678, 8'hF6, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0014, 32'hCA34_560D, 8'h00, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_3FFC, 32'hA5A5_A5A5, 8'h0F, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_3FFC, 32'hA5A5_A5A5, 8'h00, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h0102_0304, 8'h0F, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 8'h0F, 2'b10});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0102_0304, 8'h00, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_4000, 32'h0000_0000, 8'h00, 2'b10});
    vecs.push_back('{1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 8'h0F, 2'b10});
    vecs.push_back('{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 8'h00, 2'b10});
    vecs.push_back('{1'b0, 32'h8000_3FFC, 32'hA5A5_A5A5, 8'h00, 2'b00});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h1111_1111, 8'h0F, 2'b10});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 8'h00, 2'b10});
    vecs.push_back('{1'b0, 32'h8000_0013, 32'hDEAD_BEAA, 8'h00, 2'b00});

    rst = 1'b1;
    arvalid = 1'b0; araddr = '0; rready = 1'b1;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_readies", {61'd0, arready, awready, wready}, {61'd0, 3'b111});
    check("reset_valids", {62'd0, rvalid, bvalid}, 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_resps", {60'd0, rresp, bresp}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, $sformatf("vec%0d", i));
      else
        do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, 0, $sformatf("vec%0d", i));
    end

    // W beat three cycles ahead of AW
    wdata = 32'h1357_9BDF; wstrb = 8'h0F; wvalid = 1'b1;
    awaddr = 32'h8000_0030;
    @(posedge clk);
    #1 wvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("wfirst_c%0d_ready", c), {62'd0, wready, awready}, {62'd0, 1'b0, 1'b1});
      if (c == 2) begin
        @(posedge clk);
        #1 awvalid = 1'b1;
      end else if (c < 3) begin
        @(posedge clk);
      end
    end
    @(posedge clk);
    #1 awvalid = 1'b0;
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("wfirst_c%0d_bvalid", c - 1), 64'(bvalid), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("wfirst_bvalid_at_5", {62'd0, bvalid, bresp == 2'b00}, {62'd0, 1'b1, 1'b1});
    @(posedge clk);
    @(negedge clk);
    check("wfirst_readies_back", {62'd0, awready, wready}, {62'd0, 2'b11});
    @(posedge clk);
    #1;
    do_read(32'h8000_0030, 32'h1357_9BDF, 2'b00, 0, "wfirst_readback");

    // Backpressure on out-of-range and in-range responses
    do_read(32'h0000_0000, 32'h0000_0000, 2'b10, 4, "bp_oor");
    do_read(32'h8000_0010, 32'hDEAD_BEAA, 2'b00, 4, "bp_inrange");

    // Reset landing on the commit edge of a write
    do_write(32'h8000_0020, 32'h5555_5555, 8'h0F, 2'b00, "pre_rst");
    awaddr = 32'h8000_0020; wdata = 32'h0BAD_F00D; wstrb = 8'h0F;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    saw_b = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bvalid) saw_b = 1'b1;
      n++;
    end
    check("midrst_no_bvalid", 64'(saw_b), 64'd0);
    check("midrst_readies", {61'd0, arready, awready, wready}, {61'd0, 3'b111});
    @(posedge clk);
    #1;
    do_read(32'h8000_0020, 32'h5555_5555, 2'b00, 0, "midrst_readback");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
